// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end feeding the IF/ID pipeline register. Owns the
//   program counter, issues one-outstanding-request fetches to the Icache and
//   holds one returned instruction while ID is stalled. Redirects (branch,
//   jalr, soft address reset) update the PC; a response that a redirect has
//   made stale is dropped.
//
// Ports
//   clk, rst               clock, synchronous active-low reset
//   address_rst            soft restart to RESET_PC (ignores Dstall)
//   Dstall                 downstream hold, IF/ID does not capture while high
//   flush / branch_target  branch redirect (wins over jalr)
//   flush_jalr/jalr_target jalr redirect
//   icache_req/addr/ready  fetch request handshake (accepted when req&ready)
//   icache_rvalid/rdata    fetch response
//   PC_added, Icache_out   held instruction address+4 and instruction
//   Istall                 high whenever no valid instruction is offered
//   dbg_state              current FSM state (IDLE=0 WAIT=1 HOLD=2 DISCARD=3)
//
// Handshake: a request transfers on a rising edge where icache_req and
// icache_ready are both high; icache_rvalid is only honoured in WAIT/DISCARD,
// and an instruction is consumed on an edge where Istall=0 and Dstall=0.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                   DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0,
    parameter logic [DATA_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 address_rst,
    input  logic                 Dstall,
    input  logic                 flush,
    input  logic [DATA_SIZE-1:0] branch_target,
    input  logic                 flush_jalr,
    input  logic [DATA_SIZE-1:0] jalr_target,
    output logic                 icache_req,
    output logic [DATA_SIZE-1:0] icache_addr,
    input  logic                 icache_ready,
    input  logic                 icache_rvalid,
    input  logic [DATA_SIZE-1:0] icache_rdata,
    output logic [DATA_SIZE-1:0] PC_added,
    output logic [DATA_SIZE-1:0] Icache_out,
    output logic                 Istall,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] pc_q, pc_d;
    logic [DATA_SIZE-1:0] instr_q, instr_d;
    logic [DATA_SIZE-1:0] pc_added_q, pc_added_d;

    logic                 redirect;
    logic [DATA_SIZE-1:0] target_raw;
    logic [DATA_SIZE-1:0] target;
    logic [DATA_SIZE-1:0] pc_plus4;

    // address_rst beats any flush and ignores Dstall; flush beats flush_jalr
    // because it belongs to the older instruction.
    always_comb begin
        redirect   = address_rst | (~Dstall & (flush | flush_jalr));
        target_raw = address_rst ? RESET_PC :
                     flush       ? branch_target : jalr_target;
        target     = target_raw & ~DATA_SIZE'(3);
        pc_plus4   = pc_q + DATA_SIZE'(4);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_added_d = pc_added_q;
        case (state_q)
            S_IDLE: begin
                // A redirect on an accepted request still completes the
                // handshake, so that response must be thrown away.
                if (redirect) begin
                    pc_d    = target;
                    state_d = icache_ready ? S_DISCARD : S_IDLE;
                end else if (icache_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = icache_rvalid ? S_IDLE : S_DISCARD;
                end else if (icache_rvalid) begin
                    instr_d    = icache_rdata;
                    pc_added_d = pc_plus4;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // On redirect the held instruction is dropped, not consumed.
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_IDLE;
                end else if (!Dstall) begin
                    pc_d    = pc_plus4;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (icache_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_added_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_added_q <= pc_added_d;
        end
    end

    // The buffer is valid only in HOLD; elsewhere present a NOP bubble.
    always_comb begin
        icache_req  = (state_q == S_IDLE);
        icache_addr = pc_q;
        Istall      = (state_q != S_HOLD);
        Icache_out  = (state_q == S_HOLD) ? instr_q    : NOP_INSTR;
        PC_added    = (state_q == S_HOLD) ? pc_added_q : '0;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, address_rst, Dstall, flush, flush_jalr;
  logic [W-1:0] branch_target, jalr_target;
  logic         icache_req, icache_ready, icache_rvalid;
  logic [W-1:0] icache_addr, icache_rdata;
  logic [W-1:0] PC_added, Icache_out;
  logic         Istall;
  logic [1:0]   dbg_state;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .address_rst(address_rst), .Dstall(Dstall),
    .flush(flush), .branch_target(branch_target),
    .flush_jalr(flush_jalr), .jalr_target(jalr_target),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rvalid(icache_rvalid),
    .icache_rdata(icache_rdata), .PC_added(PC_added),
    .Icache_out(Icache_out), .Istall(Istall), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_addr_q[$];
  logic [W-1:0] exp_instr_q[$];
  logic [W-1:0] exp_pcadd_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Icache responder ----------------
  logic         force_rvalid = 1'b0;
  logic         acc_seen = 1'b0;
  logic [W-1:0] acc_addr = '0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return 32'h0050_0093 ^ a;
  endfunction

  initial begin
    icache_rvalid = 1'b0;
    icache_rdata  = '0;
    forever begin
      @(negedge clk);
      acc_seen = (icache_req === 1'b1) && (icache_ready === 1'b1) && (rst === 1'b1);
      acc_addr = icache_addr;
      @(posedge clk);
      #2;
      icache_rvalid = acc_seen | force_rvalid;
      icache_rdata  = acc_seen ? mem_word(acc_addr) : 32'hDEAD_BEEF;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && icache_req === 1'b1 && icache_ready === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got %h expected none", icache_addr);
      end else begin
        check("fetch_addr", icache_addr, exp_addr_q.pop_front());
      end
    end
    if (rst === 1'b1 && Istall === 1'b0 && Dstall === 1'b0 && !flush && !flush_jalr && !address_rst) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %h expected none", Icache_out);
      end else begin
        check("instr_out", Icache_out, exp_instr_q.pop_front());
        check("pc_added", PC_added, exp_pcadd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n = 0;
    do begin
      step();
      n++;
    end while (dbg_state !== s && n < 40);
    check("wait_state", {30'b0, dbg_state}, {30'b0, s});
  endtask

  task automatic push_instr(input logic [W-1:0] instr, input logic [W-1:0] pcadd);
    exp_instr_q.push_back(instr);
    exp_pcadd_q.push_back(pcadd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; address_rst = 1'b0; Dstall = 1'b0; flush = 1'b0; flush_jalr = 1'b0;
    branch_target = '0; jalr_target = '0; icache_ready = 1'b1;
    repeat (2) step();
    check("reset_istall", {31'b0, Istall}, 32'd1);
    check("reset_out", Icache_out, 32'h0000_0013);
    check("reset_pcadd", PC_added, 32'h0);
    check("reset_req", {31'b0, icache_req}, 32'd1);

    // basic fetch, then Dstall hold in HOLD
    exp_addr_q.push_back(32'h0);
    push_instr(32'h0050_0093, 32'h4);
    exp_addr_q.push_back(32'h4);
    rst = 1'b1;
    step();
    check("t1_wait_state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    check("t1_wait_req", {31'b0, icache_req}, 32'd0);
    step();
    Dstall = 1'b1;
    check("t1_istall", {31'b0, Istall}, 32'd0);
    check("t1_out", Icache_out, 32'h0050_0093);
    check("t1_pcadd", PC_added, 32'h4);
    repeat (3) begin
      step();
      check("t2_hold_istall", {31'b0, Istall}, 32'd0);
      check("t2_hold_out", Icache_out, 32'h0050_0093);
      check("t2_hold_pcadd", PC_added, 32'h4);
      check("t2_hold_noreq", {31'b0, icache_req}, 32'd0);
    end
    Dstall = 1'b0;
    step();
    check("t2_next_req", {31'b0, icache_req}, 32'd1);
    check("t2_next_addr", icache_addr, 32'h4);

    // flush in WAIT (response dropped), target low bits masked
    step();
    check("t3_wait", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    flush = 1'b1; branch_target = 32'h103;
    step();
    flush = 1'b0;
    exp_addr_q.push_back(32'h100);
    check("t3_istall", {31'b0, Istall}, 32'd1);
    check("t3_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("t3_addr", icache_addr, 32'h100);

    // flush and flush_jalr together in HOLD: flush wins, buffer dropped
    wait_state(ST_HOLD);
    check("t4_pre_out", Icache_out, 32'h0050_0193);
    flush = 1'b1; branch_target = 32'h200;
    flush_jalr = 1'b1; jalr_target = 32'h300;
    step();
    flush = 1'b0; flush_jalr = 1'b0;
    exp_addr_q.push_back(32'h200);
    check("t4_out", Icache_out, 32'h0000_0013);
    check("t4_istall", {31'b0, Istall}, 32'd1);
    check("t4_pcadd", PC_added, 32'h0);
    check("t4_addr", icache_addr, 32'h200);

    // jalr alone in HOLD to reach pc 0x40
    wait_state(ST_HOLD);
    check("t5_pre_out", Icache_out, 32'h0050_0293);
    check("t5_pre_pcadd", PC_added, 32'h204);
    flush_jalr = 1'b1; jalr_target = 32'h40;
    step();
    flush_jalr = 1'b0;
    exp_addr_q.push_back(32'h40);
    check("t5_jalr_addr", icache_addr, 32'h40);

    // address_rst with Dstall in HOLD
    wait_state(ST_HOLD);
    check("t6_pre_out", Icache_out, 32'h0050_00D3);
    check("t6_pre_pcadd", PC_added, 32'h44);
    Dstall = 1'b1; address_rst = 1'b1;
    step();
    address_rst = 1'b0; Dstall = 1'b0;
    exp_addr_q.push_back(32'h0);
    check("t6_istall", {31'b0, Istall}, 32'd1);
    check("t6_out", Icache_out, 32'h0000_0013);
    check("t6_addr", icache_addr, 32'h0);

    // wrap-around from 0xFFFF_FFFC
    wait_state(ST_HOLD);
    check("t7_pre_out", Icache_out, 32'h0050_0093);
    flush = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_instr(32'hFFAF_FF6F, 32'h0);
    exp_addr_q.push_back(32'h0);
    check("t7_addr", icache_addr, 32'hFFFF_FFFC);
    wait_state(ST_HOLD);
    check("t7_wrap_pcadd", PC_added, 32'h0);

    // reset in WAIT, late rvalid ignored
    wait_state(ST_WAIT);
    rst = 1'b0; force_rvalid = 1'b1; icache_ready = 1'b0;
    step();
    rst = 1'b1;
    check("t8_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("t8_istall", {31'b0, Istall}, 32'd1);
    check("t8_out", Icache_out, 32'h0000_0013);
    check("t8_addr", icache_addr, 32'h0);
    step();
    force_rvalid = 1'b0;
    check("t8_late_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("t8_late_istall", {31'b0, Istall}, 32'd1);
    check("t8_late_pcadd", PC_added, 32'h0);
    exp_addr_q.push_back(32'h0);
    push_instr(32'h0050_0093, 32'h4);
    icache_ready = 1'b1;
    wait_state(ST_HOLD);
    icache_ready = 1'b0;
    check("t9_out", Icache_out, 32'h0050_0093);
    repeat (3) step();
    check("end_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("end_addr_q", exp_addr_q.size(), 32'd0);
    check("end_instr_q", exp_instr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that produces the IF-stage outputs consumed by the IF/ID pipeline register: PC_added, Icache_out and Istall. It owns the program counter and issues one-outstanding-request fetches to the Icache over a req/ready and rvalid handshake. It buffers one returned instruction while ID is stalled. It redirects on branch, jalr and address-reset events, and discards any in-flight response that has been made stale by a redirect.

Parameters:
DATA_SIZE, 32, width of PC and instruction (matches `data_size)
RESET_PC, 32'h0000_0000, PC loaded on reset and on address_rst
NOP_INSTR, 32'h0000_0013, Icache_out value whenever no valid instruction is held

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
address_rst  in  1  soft restart: PC to RESET_PC, buffer dropped
Dstall  in  1  downstream hold; IF/ID does not capture while high
flush  in  1  branch redirect request
branch_target  in  DATA_SIZE  redirect PC for flush
flush_jalr  in  1  jalr redirect request
jalr_target  in  DATA_SIZE  redirect PC for flush_jalr
icache_req  out  1  fetch request valid
icache_addr  out  DATA_SIZE  fetch address
icache_ready  in  1  Icache accepts request this cycle
icache_rvalid  in  1  instruction data valid
icache_rdata  in  DATA_SIZE  instruction data
PC_added  out  DATA_SIZE  address of held instruction + 4
Icache_out  out  DATA_SIZE  held instruction
Istall  out  1  high when no valid instruction is offered

Behaviour:
- Reset (rst==0 at posedge), overriding every other input:
  - pc=RESET_PC, state=IDLE, buffer invalid.
  - PC_added=0, Icache_out=NOP_INSTR, Istall=1.
  - icache_req becomes 1 in the first cycle after reset.
- States:
  - IDLE: icache_req=1, icache_addr=pc.
    - icache_ready=1 -> WAIT.
  - WAIT: icache_req=0.
    - icache_rvalid -> capture rdata into Icache_out, PC_added=pc+4 -> HOLD.
  - HOLD: Istall=0; Istall=1 in every other state.
    - !Dstall: instruction is consumed at this edge, pc<=pc+4 -> IDLE.
    - Dstall: hold Icache_out and PC_added unchanged.
  - DISCARD: icache_req=0.
    - icache_rvalid: drop data -> IDLE.
- Throughput: minimum 3 cycles per instruction (IDLE, WAIT, HOLD) with single-cycle Icache response.
- Redirect:
  - Valid only when !Dstall.
  - flush has priority over flush_jalr (older instruction wins).
  - Target bits [1:0] are forced to 0.
  - IDLE, ready=0: pc<=target, stay IDLE; new address presented next cycle. An unaccepted request may change address.
  - IDLE, ready=1: handshake completes, pc<=target -> DISCARD.
  - WAIT, rvalid=0: pc<=target -> DISCARD.
  - WAIT, rvalid=1: data dropped, pc<=target -> IDLE.
  - HOLD: buffer dropped (Icache_out=NOP_INSTR, PC_added=0, Istall=1), pc<=target -> IDLE. The held instruction is not consumed.
  - DISCARD: pc<=target, stay DISCARD; or -> IDLE if rvalid that cycle.
- address_rst:
  - Applies regardless of Dstall and has priority over flush/flush_jalr.
  - Same handling as a redirect to RESET_PC.
- Icache rules:
  - At most one outstanding request.
  - icache_rvalid outside WAIT/DISCARD is ignored.
  - icache_addr is meaningful only while icache_req=1.
- Wrap-around: pc+4 wraps modulo 2^DATA_SIZE (0xFFFF_FFFC -> 0x0000_0000).
- Dstall alone never blocks IDLE or WAIT progress; a fetch may complete while downstream is stalled and then wait in HOLD.

Test Plan:
- Release reset, icache_ready=1, rvalid one cycle after accept with rdata=0x00500093 -> icache_addr=0x0. Third cycle: Istall=0, Icache_out=0x00500093, PC_added=0x4. Next request at 0x4.
- In HOLD, Dstall=1 for 3 cycles -> Icache_out, PC_added and Istall=0 held. No new request until the cycle after Dstall falls.
- flush=1, branch_target=0x100 while in WAIT -> the returning rdata is discarded, Istall stays 1. Next icache_addr=0x100.
- flush=1 (target 0x200) and flush_jalr=1 (target 0x300) in the same HOLD cycle -> buffer dropped, Icache_out=0x13. Next icache_addr=0x200.
- address_rst=1 with Dstall=1 in HOLD at pc=0x40 -> Istall=1. Next icache_addr=RESET_PC.
- pc=0xFFFF_FFFC consumed -> next icache_addr=0x0. rst=0 mid-WAIT -> IDLE at RESET_PC, and a late rvalid is ignored.
